pipe_hazard_chain: RTL and testbench
====================================

Name: pipe_hazard_chain

Overview:
Parametrised, hazard-aware chain of pipeline registers that replaces the hand-wired IF/ID, ID/EX, EX/MEM and MEM/WB registers of the core.
- Stage count and payload width are parameters.
- Load-use stall with bubble insertion is detected internally.
- Branch flush kills a parametrised number of young slots.
- Global external freeze.
- Emits forwarding selects for the operands in stage 1.
- Sits between fetch and register writeback; the datapath drives stage 0 and consumes the last stage.

Parameters:
- STAGES, 4, number of register stages (min 3); stage 0 is youngest, STAGES-1 is oldest.
- DATA_W, 64, opaque payload width per stage.
- RA_W, 5, register address width.
- FLUSH_DEPTH, 2, number of youngest stages invalidated on flush (1..STAGES-1).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- in_valid  in  1  new instruction offered to stage 0.
- in_data  in  DATA_W  payload.
- in_rd  in  RA_W  destination register.
- in_rs1  in  RA_W  source register 1.
- in_rs2  in  RA_W  source register 2.
- in_wen  in  1  instruction writes rd.
- in_load  in  1  instruction is a memory load.
- in_ready  out  1  input accepted this cycle.
- stall_ext  in  1  freeze the entire chain (memory wait).
- flush  in  1  branch taken; kill young slots.
- fwd_a_hit  out  1  stage-1 rs1 has an older in-flight producer.
- fwd_a_idx  out  $clog2(STAGES)  index of the producing stage.
- fwd_b_hit  out  1  same as fwd_a_hit, for rs2.
- fwd_b_idx  out  $clog2(STAGES)  same as fwd_a_idx, for rs2.
- lu_stall  out  1  load-use stall active this cycle.
- out_valid  out  1  oldest stage valid.
- out_data  out  DATA_W  oldest stage payload.
- out_rd  out  RA_W  oldest stage rd.
- out_wen  out  1  oldest stage wen, gated by valid.

Behaviour:
- Per-stage state: valid, data, rd, rs1, rs2, wen, load.
- Reset: all valid=0 and all fields=0. Outputs are therefore out_valid=0, out_wen=0, out_data=0, out_rd=0, fwd_*_hit=0, fwd_*_idx=0, lu_stall=0, in_ready=0 while reset is high.
- Latency: an entry accepted at edge N appears at the last stage after edge N+STAGES-1 if no stall or flush occurs.
- Per-edge priority: reset > stall_ext > flush > load-use > normal advance.
- stall_ext=1: every register holds; in_ready=0; lu_stall still reported; flush is ignored and must be held by the source.
- Normal advance: stage k <= stage k-1; stage 0 <= input; in_ready=1; in_valid=0 loads a bubble (valid=0).
- Load-use condition, combinational: s1.valid & s1.load & s1.rd!=0 & s0.valid & (s1.rd==s0.rs1 | s1.rd==s0.rs2).
  - Response: lu_stall=1; stage 0 holds; stage 1 <= bubble; stages >=2 advance; in_ready=0.
- Flush (with stall_ext=0): the chain advances normally, then stages 0..FLUSH_DEPTH-1 are forced valid=0.
  - in_ready=1 and the offered input is consumed and discarded.
  - Flush overrides load-use: lu_stall is still reported, but stage 0 is not held.
- Forwarding, combinational from stage-1 rs1/rs2:
  - Scan stages 2..STAGES-1 in ascending order (nearest first); the first stage with valid & wen & rd!=0 & rd==rs wins.
  - hit=1 and idx=that stage; otherwise hit=0, idx=0.
  - A winning stage with load=1 only occurs at index >=3, because the load-use stall guarantees this.
- Register 0: never a hazard source and never a forwarding match.
- Bubbles always carry wen=0 and load=0 as well as valid=0.

Optional Feature:
PIPE_PERF_EN: when defined, adds three outputs, each 32-bit, saturating at 32'hFFFFFFFF and cleared by reset:
- perf_lu_cnt: cycles with lu_stall=1 and stall_ext=0.
- perf_flush_cnt: valid entries killed by flush.
- perf_retire_cnt: cycles with out_valid=1 and stall_ext=0.

When PIPE_PERF_EN is undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then stream 4 entries (data=1..4, rd=1..4, no sources) with defaults -> data 1 on out_valid after edge 4, then 2,3,4 on consecutive cycles.
- Load rd=5 followed by an entry with rs1=5 -> lu_stall=1 for exactly 1 cycle, in_ready=0, one bubble behind the load; the consumer then reaches stage 1 with fwd_a_hit=1, fwd_a_idx=3 (STAGES=4).
- ALU op rd=7 followed by an entry with rs2=7 -> no stall; fwd_b_hit=1, fwd_b_idx=2; rd=0 producer with rs1=0 -> fwd_a_hit=0.
- Flush pulse with 4 valid entries -> after the edge stages 0,1 are invalid and stages 2,3 hold the advanced older entries; the offered input is discarded.
- stall_ext=1 for 3 cycles mid-stream with flush=1 on the middle cycle -> all state frozen, flush has no effect, and the stream resumes unchanged.
- Reset asserted while the pipeline is full and a load-use is active -> next edge: all valid=0, lu_stall=0; with PIPE_PERF_EN, all counters read 0.

Source files
------------

// File: rtl/pipe_hazard_chain_if.sv
// Bus between the datapath and the hazard-aware pipeline register chain.
// The datapath is the master: it offers instructions, freezes and flushes the chain,
// and receives the retiring entry together with the stall and forwarding information.
// PIPE_PERF_EN adds three performance counter outputs to the slave side.
interface pipe_hazard_chain_if #(
  parameter int STAGES = 4,
  parameter int DATA_W = 64,
  parameter int RA_W   = 5
);
  localparam int IDX_W = $clog2(STAGES);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [RA_W-1:0]   in_rd;
  logic [RA_W-1:0]   in_rs1;
  logic [RA_W-1:0]   in_rs2;
  logic              in_wen;
  logic              in_load;
  logic              in_ready;
  logic              stall_ext;
  logic              flush;
  logic              fwd_a_hit;
  logic [IDX_W-1:0]  fwd_a_idx;
  logic              fwd_b_hit;
  logic [IDX_W-1:0]  fwd_b_idx;
  logic              lu_stall;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [RA_W-1:0]   out_rd;
  logic              out_wen;
`ifdef PIPE_PERF_EN
  logic [31:0]       perf_lu_cnt;
  logic [31:0]       perf_flush_cnt;
  logic [31:0]       perf_retire_cnt;
`endif

  modport master (
    output in_valid, in_data, in_rd, in_rs1, in_rs2, in_wen, in_load,
    output stall_ext, flush,
    input  in_ready, lu_stall,
    input  fwd_a_hit, fwd_a_idx, fwd_b_hit, fwd_b_idx,
    input  out_valid, out_data, out_rd, out_wen
`ifdef PIPE_PERF_EN
    , input perf_lu_cnt, perf_flush_cnt, perf_retire_cnt
`endif
  );

  modport slave (
    input  in_valid, in_data, in_rd, in_rs1, in_rs2, in_wen, in_load,
    input  stall_ext, flush,
    output in_ready, lu_stall,
    output fwd_a_hit, fwd_a_idx, fwd_b_hit, fwd_b_idx,
    output out_valid, out_data, out_rd, out_wen
`ifdef PIPE_PERF_EN
    , output perf_lu_cnt, perf_flush_cnt, perf_retire_cnt
`endif
  );
endinterface

// File: rtl/pipe_hazard_chain.sv
// Hazard-aware chain of pipeline registers (stage 0 youngest, STAGES-1 oldest).
// Detects load-use hazards between stages 1 and 0 and inserts a bubble.
// Applies branch flushes to the youngest FLUSH_DEPTH slots and honours a global freeze.
// Reports forwarding sources for the stage-1 operands.
// Optional macro PIPE_PERF_EN adds saturating performance counters.
module pipe_hazard_chain #(
  parameter int STAGES      = 4,
  parameter int DATA_W      = 64,
  parameter int RA_W        = 5,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  pipe_hazard_chain_if.slave bus
);
  localparam int IDX_W = $clog2(STAGES);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [RA_W-1:0]   rd;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic              wen;
    logic              load;
  } stage_t;

  stage_t st [STAGES];
  stage_t in_entry;

  logic             lu_hit;
  logic             hold_s0;
  logic             fa_hit;
  logic             fb_hit;
  logic [IDX_W-1:0] fa_idx;
  logic [IDX_W-1:0] fb_idx;

  // Bubbles are all-zero, so a dead slot can never look like a producer or a consumer.
  always_comb begin
    in_entry = '0;
    if (bus.in_valid) begin
      in_entry.valid = 1'b1;
      in_entry.data  = bus.in_data;
      in_entry.rd    = bus.in_rd;
      in_entry.rs1   = bus.in_rs1;
      in_entry.rs2   = bus.in_rs2;
      in_entry.wen   = bus.in_wen;
      in_entry.load  = bus.in_load;
    end
  end

  // A load in stage 1 whose result is needed by stage 0 cannot be forwarded in time.
  assign lu_hit = st[1].valid && st[1].load && (st[1].rd != '0) && st[0].valid &&
                  ((st[1].rd == st[0].rs1) || (st[1].rd == st[0].rs2));

  // A flush discards stage 0 anyway, so it overrides the load-use hold.
  assign hold_s0 = lu_hit && !bus.flush;

  assign bus.lu_stall = lu_hit && !reset;
  assign bus.in_ready = !reset && !bus.stall_ext && !hold_s0;

  // Nearest-older producer search: scanning oldest to youngest lets the nearest match win.
  always_comb begin
    fa_hit = 1'b0;
    fa_idx = '0;
    fb_hit = 1'b0;
    fb_idx = '0;
    for (int k = STAGES - 1; k >= 2; k--) begin
      if (st[k].valid && st[k].wen && (st[k].rd != '0)) begin
        if (st[k].rd == st[1].rs1) begin
          fa_hit = 1'b1;
          fa_idx = IDX_W'(k);
        end
        if (st[k].rd == st[1].rs2) begin
          fb_hit = 1'b1;
          fb_idx = IDX_W'(k);
        end
      end
    end
  end

  assign bus.fwd_a_hit = fa_hit && !reset;
  assign bus.fwd_a_idx = reset ? '0 : fa_idx;
  assign bus.fwd_b_hit = fb_hit && !reset;
  assign bus.fwd_b_idx = reset ? '0 : fb_idx;

  assign bus.out_valid = st[STAGES-1].valid;
  assign bus.out_data  = st[STAGES-1].data;
  assign bus.out_rd    = st[STAGES-1].rd;
  assign bus.out_wen   = st[STAGES-1].valid && st[STAGES-1].wen;

  // Stage registers: freeze, else advance (with bubble on load-use), then kill young slots on flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) st[k] <= '0;
    end else if (!bus.stall_ext) begin
      for (int k = STAGES - 1; k >= 2; k--) st[k] <= st[k-1];
      if (hold_s0) begin
        st[1] <= '0;
      end else begin
        st[1] <= st[0];
        st[0] <= in_entry;
      end
      if (bus.flush) begin
        for (int k = 0; k < FLUSH_DEPTH; k++) st[k] <= '0;
      end
    end
  end

`ifdef PIPE_PERF_EN
  logic [31:0] lu_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] retire_cnt;
  logic [31:0] killed;

  // Valid entries that a flush would have moved into the killed slots this edge.
  always_comb begin
    killed = 32'(bus.in_valid);
    for (int k = 1; k < FLUSH_DEPTH; k++) killed = killed + 32'(st[k-1].valid);
  end

  // Saturating event counters; nothing counts while the chain is frozen.
  always_ff @(posedge clock) begin
    if (reset) begin
      lu_cnt     <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
    end else if (!bus.stall_ext) begin
      if (lu_hit && (lu_cnt != '1)) lu_cnt <= lu_cnt + 32'd1;
      if (bus.flush) flush_cnt <= (flush_cnt > (32'hFFFF_FFFF - killed)) ? '1 : flush_cnt + killed;
      if (st[STAGES-1].valid && (retire_cnt != '1)) retire_cnt <= retire_cnt + 32'd1;
    end
  end

  assign bus.perf_lu_cnt     = lu_cnt;
  assign bus.perf_flush_cnt  = flush_cnt;
  assign bus.perf_retire_cnt = retire_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_chain.sv
// Self-checking bench for pipe_hazard_chain: a directed vector table, hand-written
// corner sequences, and a random run, all shadowed by a queue-based reference model.
module tb_pipe_hazard_chain;
  localparam int STAGES = 4;
  localparam int DATA_W = 64;
  localparam int RA_W   = 5;
  localparam int FD     = 2;

  logic clock;
  logic reset;

  pipe_hazard_chain_if #(.STAGES(STAGES), .DATA_W(DATA_W), .RA_W(RA_W)) bus ();

  pipe_hazard_chain #(.STAGES(STAGES), .DATA_W(DATA_W), .RA_W(RA_W), .FLUSH_DEPTH(FD)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          rst;
    bit          v;
    logic [63:0] d;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    bit          wen;
    bit          load;
    bit          stall;
    bit          flush;
  } in_t;

  typedef struct {
    bit          valid;
    logic [63:0] data;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    bit          wen;
    bit          load;
  } ent_t;

  typedef struct {
    in_t         i;
    bit          e_valid;
    logic [63:0] e_data;
    bit          e_ready;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  bit model_ok = 0;
  ent_t pipe [$];
  logic [63:0] retired [$];

  logic        obs_ready, obs_lu, obs_ov, obs_fah, obs_fbh;
  logic [1:0]  obs_fai, obs_fbi;
  logic [63:0] obs_od;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(bit v, logic [63:0] d, logic [4:0] rd, logic [4:0] rs1,
                             logic [4:0] rs2, bit wen, bit load);
    in_t r;
    r.rst = 0; r.v = v; r.d = d; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.wen = wen; r.load = load; r.stall = 0; r.flush = 0;
    return r;
  endfunction

  function automatic in_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic ent_t bubble();
    ent_t e;
    e.valid = 0; e.data = 0; e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.wen = 0; e.load = 0;
    return e;
  endfunction

  // A load one slot ahead of a reader of its destination cannot be bypassed.
  function automatic bit model_lu();
    ent_t p, c;
    p = pipe[1];
    c = pipe[0];
    return p.valid && p.load && p.rd != 0 && c.valid && (p.rd == c.rs1 || p.rd == c.rs2);
  endfunction

  // Nearest older writer of register rs among stages 2.. (returns hit, index).
  function automatic logic [2:0] model_fwd(logic [4:0] rs);
    for (int k = 2; k < STAGES; k++) begin
      if (pipe[k].valid && pipe[k].wen && pipe[k].rd != 0 && pipe[k].rd == rs)
        return {1'b1, 2'(k)};
    end
    return 3'b000;
  endfunction

  task automatic step(input in_t i);
    bit lu, e_ready, e_lu;
    ent_t o, ne;
    logic [2:0] fa, fb;
    @(negedge clock);
    reset         = i.rst;
    bus.in_valid  = i.v;
    bus.in_data   = i.d;
    bus.in_rd     = i.rd;
    bus.in_rs1    = i.rs1;
    bus.in_rs2    = i.rs2;
    bus.in_wen    = i.wen;
    bus.in_load   = i.load;
    bus.stall_ext = i.stall;
    bus.flush     = i.flush;
    #1;
    obs_ready = bus.in_ready; obs_lu = bus.lu_stall; obs_ov = bus.out_valid; obs_od = bus.out_data;
    obs_fah = bus.fwd_a_hit; obs_fai = bus.fwd_a_idx; obs_fbh = bus.fwd_b_hit; obs_fbi = bus.fwd_b_idx;
    lu = model_lu();
    if (model_ok) begin
      e_ready = !i.rst && !i.stall && (!lu || i.flush);
      e_lu    = !i.rst && lu;
      o  = pipe[STAGES-1];
      fa = i.rst ? 3'b000 : model_fwd(pipe[1].rs1);
      fb = i.rst ? 3'b000 : model_fwd(pipe[1].rs2);
      chk("mdl_ready", 128'(bus.in_ready), 128'(e_ready));
      chk("mdl_lu", 128'(bus.lu_stall), 128'(e_lu));
      chk("mdl_out", {bus.out_valid, bus.out_wen, bus.out_rd, bus.out_data},
          {o.valid, o.valid & o.wen, o.rd, o.data});
      chk("mdl_fwd", {bus.fwd_a_hit, bus.fwd_a_idx, bus.fwd_b_hit, bus.fwd_b_idx}, {fa, fb});
      if (!i.rst && !i.stall && o.valid) retired.push_back(o.data);
    end
    @(posedge clock);
    if (i.rst) begin
      foreach (pipe[k]) pipe[k] = bubble();
      model_ok = 1;
    end else if (!i.stall) begin
      ne = bubble();
      if (i.v) begin
        ne.valid = 1; ne.data = i.d; ne.rd = i.rd; ne.rs1 = i.rs1; ne.rs2 = i.rs2;
        ne.wen = i.wen; ne.load = i.load;
      end
      if (i.flush || !lu) pipe.push_front(ne);
      else pipe.insert(1, bubble());
      void'(pipe.pop_back());
      if (i.flush) for (int k = 0; k < FD; k++) pipe[k] = bubble();
    end
  endtask

  task automatic do_reset();
    in_t r;
    r = idle();
    r.rst = 1;
    step(r);
    step(r);
  endtask

  task automatic drain();
    for (int k = 0; k < STAGES; k++) step(idle());
  endtask

  function automatic vec_t mkv(in_t i, bit ev, logic [63:0] ed, bit er);
    vec_t v;
    v.i = i; v.e_valid = ev; v.e_data = ed; v.e_ready = er;
    return v;
  endfunction

  vec_t tbl [9];

  initial begin
    in_t t;
    for (int k = 0; k < STAGES; k++) pipe.push_back(bubble());
    reset = 1;
    bus.in_valid = 0; bus.in_data = 0; bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
    bus.in_wen = 0; bus.in_load = 0; bus.stall_ext = 0; bus.flush = 0;

    for (int k = 0; k < 4; k++) tbl[k] = mkv(mk(1, 64'(k + 1), 5'(k + 1), 0, 0, 1, 0), 0, 0, 1);
    for (int k = 4; k < 8; k++) tbl[k] = mkv(idle(), 1, 64'(k - 3), 1);
    tbl[8] = mkv(idle(), 0, 0, 1);

    // Reset state
    do_reset();
    t = idle(); t.rst = 1;
    step(t);
    chk("rst_out_valid", 128'(obs_ov), 0);
    chk("rst_ready", 128'(obs_ready), 0);
    chk("rst_lu", 128'(obs_lu), 0);
    chk("rst_fwd", {obs_fah, obs_fai, obs_fbh, obs_fbi}, 0);

    // Streaming table
    foreach (tbl[r]) begin
      step(tbl[r].i);
      chk("tbl_valid", 128'(obs_ov), 128'(tbl[r].e_valid));
      if (tbl[r].e_valid) chk("tbl_data", 128'(obs_od), 128'(tbl[r].e_data));
      chk("tbl_ready", 128'(obs_ready), 128'(tbl[r].e_ready));
    end

    // Load-use: one bubble, then forward from stage 3
    drain();
    step(mk(1, 64'h50, 5, 0, 0, 1, 1));
    step(mk(1, 64'h51, 6, 5, 0, 1, 0));
    step(idle());
    chk("lu_active", 128'(obs_lu), 1);
    chk("lu_ready", 128'(obs_ready), 0);
    step(idle());
    chk("lu_one_cycle", 128'(obs_lu), 0);
    step(idle());
    chk("lu_fwd_a", {obs_fah, obs_fai}, {1'b1, 2'd3});

    // ALU forwarding from stage 2; rd=0 is never a source
    drain();
    step(mk(1, 64'h60, 0, 0, 0, 1, 0));
    step(mk(1, 64'h61, 7, 0, 0, 1, 0));
    step(mk(1, 64'h62, 8, 0, 7, 1, 0));
    chk("alu_no_lu", 128'(obs_lu), 0);
    step(idle());
    step(idle());
    chk("alu_fwd_b", {obs_fbh, obs_fbi}, {1'b1, 2'd2});
    chk("rd0_fwd_a", 128'(obs_fah), 0);

    // Flush with four valid entries
    drain();
    for (int k = 0; k < 4; k++) step(mk(1, 64'(11 + k), 1, 0, 0, 1, 0));
    t = mk(1, 15, 1, 0, 0, 1, 0); t.flush = 1;
    step(t);
    chk("flush_ready", 128'(obs_ready), 1);
    chk("flush_out", {obs_ov, obs_od}, {1'b1, 64'd11});
    step(idle());
    chk("flush_old2", {obs_ov, obs_od}, {1'b1, 64'd12});
    step(idle());
    chk("flush_old3", {obs_ov, obs_od}, {1'b1, 64'd13});
    step(idle());
    chk("flush_kill0", 128'(obs_ov), 0);
    step(idle());
    chk("flush_kill1", 128'(obs_ov), 0);

    // Freeze for three cycles, flush ignored in the middle
    drain();
    retired.delete();
    for (int k = 0; k < 3; k++) step(mk(1, 64'(21 + k), 2, 0, 0, 1, 0));
    for (int k = 0; k < 3; k++) begin
      t = mk(1, 99, 3, 0, 0, 1, 0); t.stall = 1; t.flush = (k == 1);
      step(t);
      chk("stall_ready", 128'(obs_ready), 0);
    end
    step(mk(1, 24, 2, 0, 0, 1, 0));
    drain();
    chk("stall_retire_n", 128'(retired.size()), 4);
    for (int k = 0; k < 4 && k < retired.size(); k++)
      chk("stall_retire", 128'(retired[k]), 128'(21 + k));

    // Reset while full with a load-use pending
    drain();
    step(mk(1, 31, 1, 0, 0, 1, 0));
    step(mk(1, 32, 2, 0, 0, 1, 0));
    step(mk(1, 33, 9, 0, 0, 1, 1));
    step(mk(1, 34, 4, 9, 0, 1, 0));
    t = idle(); t.rst = 1;
    step(t);
    chk("rstmid_lu", 128'(obs_lu), 0);
    chk("rstmid_ready", 128'(obs_ready), 0);
    for (int k = 0; k < STAGES; k++) begin
      step(idle());
      chk("rstmid_empty", {obs_ov, obs_lu}, 0);
    end

    // Random traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      t = mk($urandom_range(9, 0) < 7, 64'({$urandom, $urandom}), 5'($urandom_range(3, 0)),
             5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
             $urandom_range(9, 0) < 7, $urandom_range(9, 0) < 3);
      t.stall = $urandom_range(9, 0) == 0;
      t.flush = $urandom_range(99, 0) < 6;
      t.rst   = $urandom_range(199, 0) == 0;
      step(t);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
